// File: rtl/switch_debounce_pkg.sv
// Shared switch/LED constants: default switch count, debounce window, press counter width.
package switch_debounce_pkg;
   localparam int NUM_SW_DEF    = 8;
   localparam int DB_CYCLES_DEF = 50000;
   localparam int PRESS_CNT_W   = 8;
endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-flop synchronizer, persistence counter, edge pulses.
// Latency DB_CYCLES+1 edges from first sampling edge; no backpressure.
module switch_debounce_ch
   import switch_debounce_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic state,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          s;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= sw;
         s     <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         // any return to the accepted level restarts the window from zero
         if (s == state) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            state <= s;
            cnt   <= '0;
            rise  <= s;
            fall  <= ~s;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/switch_debounce.sv
// Debounces NUM_SW switches in parallel and counts accepted presses (wrapping).
// Latency DB_CYCLES+1 edges to sw_state, press_cnt one edge after sw_rise; no backpressure.
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int NUM_SW    = NUM_SW_DEF,
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SW-1:0]      sw,
   output logic [NUM_SW-1:0]      sw_state,
   output logic [NUM_SW-1:0]      sw_rise,
   output logic [NUM_SW-1:0]      sw_fall,
   output logic [PRESS_CNT_W-1:0] press_cnt
);
   logic [PRESS_CNT_W-1:0] rise_cnt;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      switch_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .sw    (sw[i]),
         .state (sw_state[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
   end

   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         rise_cnt = rise_cnt + PRESS_CNT_W'(sw_rise[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         press_cnt <= '0;
      end else begin
         press_cnt <= press_cnt + rise_cnt;
      end
   end
endmodule
